// File: rtl/code_out_buffer.sv
// rtl/code_out_buffer.sv - packs variable-width codes LSB-first into a byte FIFO
// Optional ByteCount output enabled by defining OUTBUF_BYTECOUNT_EN.
module code_out_buffer #(
  parameter int CODE_W     = 9,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RequestOutBuffer,
  input  logic              CloseBuffer,
  input  logic [CODE_W-1:0] CodeIn,
  output logic              InReady,
  output logic [7:0]        ByteOut,
  output logic              ByteValid,
  input  logic              ByteReady,
  output logic              StreamDone,
  output logic              Error
`ifdef OUTBUF_BYTECOUNT_EN
  ,
  output logic [15:0]       ByteCount
`endif
);

  localparam int ACC_W = CODE_W + 7;
  localparam int BC_W  = $clog2(ACC_W + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [BC_W-1:0]  BYTE_STEP = BC_W'(8);
  localparam logic [BC_W-1:0]  CODE_STEP = BC_W'(CODE_W);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    FLUSH,
    DRAIN,
    DONE
  } stateT;

  stateT state;
  stateT nextState;

  logic [ACC_W-1:0] acc;
  logic [BC_W-1:0]  bitCount;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [CNT_W-1:0] fifoCount;
  logic             fifoFull;
  logic             fifoEmpty;

  logic       accept;
  logic       extract;
  logic       flushPartial;
  logic       clearAcc;
  logic       push;
  logic       pop;
  logic [7:0] partialMask;
  logic [7:0] pushByte;
  logic       badStrobe;

  assign fifoFull  = (fifoCount == FULL_CNT);
  assign fifoEmpty = (fifoCount == '0);
  assign ByteValid = !fifoEmpty;
  assign ByteOut   = mem[rdPtr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState    = state;
    InReady      = 1'b0;
    extract      = 1'b0;
    flushPartial = 1'b0;
    clearAcc     = 1'b0;
    StreamDone   = 1'b0;
    case (state)
      IDLE: begin
        nextState = ACCUM;
      end
      ACCUM: begin
        InReady = (bitCount < BYTE_STEP);
        extract = (bitCount >= BYTE_STEP) && !fifoFull;
        if (CloseBuffer) begin
          nextState = FLUSH;
        end
      end
      FLUSH: begin
        // Whole bytes first; the zero-padded remainder goes last, only when there is room.
        if (bitCount >= BYTE_STEP) begin
          extract = !fifoFull;
        end else if (bitCount == '0) begin
          nextState = DRAIN;
        end else if (!fifoFull) begin
          flushPartial = 1'b1;
          nextState    = DRAIN;
        end
      end
      DRAIN: begin
        if (fifoEmpty) begin
          nextState = DONE;
        end
      end
      DONE: begin
        StreamDone = 1'b1;
        clearAcc   = 1'b1;
        nextState  = ACCUM;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  assign accept    = RequestOutBuffer && InReady;
  assign badStrobe = (RequestOutBuffer && !InReady) || (CloseBuffer && (state != ACCUM));

  always_comb begin
    partialMask = '0;
    for (int i = 0; i < 8; i++) begin
      partialMask[i] = (BC_W'(i) < bitCount);
    end
  end

  assign pushByte = flushPartial ? (acc[7:0] & partialMask) : acc[7:0];
  assign push     = extract || flushPartial;
  assign pop      = ByteValid && ByteReady;

  // Accept and extract never coincide: accept needs bitCount<8, extract needs bitCount>=8.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc      <= '0;
      bitCount <= '0;
    end else if (clearAcc || flushPartial) begin
      acc      <= '0;
      bitCount <= '0;
    end else if (accept) begin
      acc      <= acc | (ACC_W'(CodeIn) << bitCount);
      bitCount <= bitCount + CODE_STEP;
    end else if (extract) begin
      acc      <= acc >> 8;
      bitCount <= bitCount - BYTE_STEP;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      fifoCount <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wrPtr] <= pushByte;
        wrPtr      <= wrPtr + PTR_W'(1);
      end
      if (pop) begin
        rdPtr <= rdPtr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   fifoCount <= fifoCount + CNT_W'(1);
        2'b01:   fifoCount <= fifoCount - CNT_W'(1);
        default: fifoCount <= fifoCount;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Error <= 1'b0;
    end else if (badStrobe) begin
      Error <= 1'b1;
    end
  end

`ifdef OUTBUF_BYTECOUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ByteCount <= '0;
    end else if (state == DONE) begin
      ByteCount <= '0;
    end else if (push && (ByteCount != 16'hFFFF)) begin
      ByteCount <= ByteCount + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_code_out_buffer.sv
// tb/tb_code_out_buffer.sv - bit-stream reference model bench for code_out_buffer
module tb_code_out_buffer;

  localparam int CODE_W     = 9;
  localparam int FIFO_DEPTH = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              RequestOutBuffer;
  logic              CloseBuffer;
  logic [CODE_W-1:0] CodeIn;
  logic              InReady;
  logic [7:0]        ByteOut;
  logic              ByteValid;
  logic              ByteReady;
  logic              StreamDone;
  logic              Error;
`ifdef OUTBUF_BYTECOUNT_EN
  logic [15:0]       ByteCount;
`endif

  code_out_buffer #(.CODE_W(CODE_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .RequestOutBuffer(RequestOutBuffer),
    .CloseBuffer     (CloseBuffer),
    .CodeIn          (CodeIn),
    .InReady         (InReady),
    .ByteOut         (ByteOut),
    .ByteValid       (ByteValid),
    .ByteReady       (ByteReady),
    .StreamDone      (StreamDone),
    .Error           (Error)
`ifdef OUTBUF_BYTECOUNT_EN
    ,
    .ByteCount       (ByteCount)
`endif
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         fails = 0;
  bit         bitQ[$];
  logic [7:0] expQ[$];
  logic [7:0] popLog[$];
  int         doneCount = 0;
  bit         expErr = 1'b0;
  bit         closePending = 1'b0;
  int         streamBytes = 0;
  int         rdyMode = 1;
  bit         prevDone = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: the output is the concatenation of accepted codes, LSB first, cut into bytes.
  function automatic void modelAccept(input logic [CODE_W-1:0] c);
    logic [7:0] b;
    for (int i = 0; i < CODE_W; i++) bitQ.push_back(c[i]);
    while (bitQ.size() >= 8) begin
      for (int j = 0; j < 8; j++) b[j] = bitQ.pop_front();
      expQ.push_back(b);
      streamBytes++;
    end
  endfunction

  function automatic void modelClose();
    logic [7:0] b;
    b = 8'h00;
    if (bitQ.size() > 0) begin
      for (int j = 0; j < bitQ.size(); j++) b[j] = bitQ[j];
      expQ.push_back(b);
      streamBytes++;
    end
    bitQ.delete();
    closePending = 1'b1;
  endfunction

  function automatic void modelClear();
    bitQ.delete();
    expQ.delete();
    expErr       = 1'b0;
    closePending = 1'b0;
    streamBytes  = 0;
  endfunction

  always @(posedge clk) begin
    #1;
    case (rdyMode)
      0:       ByteReady = 1'b0;
      1:       ByteReady = 1'b1;
      default: ByteReady = ($urandom_range(0, 3) != 0);
    endcase
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("error_flag", Error, expErr);
      if (ByteValid && ByteReady) begin
        if (expQ.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL extra_byte: got %02h expected no byte", ByteOut);
        end else begin
          check("byte_out", ByteOut, expQ.pop_front());
        end
        popLog.push_back(ByteOut);
      end
      if (StreamDone) begin
        check("done_bytes_left", expQ.size(), 0);
        check("done_after_close", closePending, 1);
        check("done_single_cycle", prevDone, 0);
`ifdef OUTBUF_BYTECOUNT_EN
        check("byte_count_at_done", ByteCount, streamBytes);
`endif
        closePending = 1'b0;
        streamBytes  = 0;
        doneCount++;
      end
`ifdef OUTBUF_BYTECOUNT_EN
      if (prevDone) check("byte_count_cleared", ByteCount, 0);
`endif
      prevDone = StreamDone;
    end else begin
      prevDone = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset            = 1'b1;
    RequestOutBuffer = 1'b0;
    CloseBuffer      = 1'b0;
    modelClear();
    repeat (2) tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic sendCode(input logic [CODE_W-1:0] c, input bit withClose, input int budget,
                          output bit ok);
    int n;
    n = 0;
    while (!InReady && n < budget) begin
      tick();
      n++;
    end
    if (!InReady) begin
      ok = 1'b0;
      return;
    end
    RequestOutBuffer = 1'b1;
    CloseBuffer      = withClose;
    CodeIn           = c;
    tick();
    RequestOutBuffer = 1'b0;
    CloseBuffer      = 1'b0;
    modelAccept(c);
    if (withClose) modelClose();
    ok = 1'b1;
  endtask

  task automatic closeStream();
    CloseBuffer = 1'b1;
    tick();
    CloseBuffer = 1'b0;
    modelClose();
  endtask

  task automatic waitDone(input string name);
    int start;
    int n;
    start = doneCount;
    n     = 0;
    while (doneCount == start && n < 2000) begin
      tick();
      n++;
    end
    check(name, doneCount != start, 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit                ok;
    int                sent;
    int                pops;
    int                n;
    bit                wc;
    logic [CODE_W-1:0] c;

    reset            = 1'b1;
    RequestOutBuffer = 1'b0;
    CloseBuffer      = 1'b0;
    CodeIn           = '0;
    ByteReady        = 1'b0;
    #1;
    check("rst_inready", InReady, 0);
    check("rst_bytevalid", ByteValid, 0);
    check("rst_byteout", ByteOut, 0);
    check("rst_streamdone", StreamDone, 0);
    check("rst_error", Error, 0);
    repeat (3) tick();
    reset = 1'b0;
    check("idle_inready", InReady, 0);
    tick();
    check("accum_inready", InReady, 1);

    // Two codes then close: FF 01 00
    popLog.delete();
    sendCode(9'h1FF, 1'b0, 20, ok);
    check("a_send0", ok, 1);
    sendCode(9'h000, 1'b0, 20, ok);
    check("a_send1", ok, 1);
    closeStream();
    waitDone("a_done");
    check("a_count", popLog.size(), 3);
    if (popLog.size() == 3) begin
      check("a_byte0", popLog[0], 8'hFF);
      check("a_byte1", popLog[1], 8'h01);
      check("a_byte2", popLog[2], 8'h00);
    end

    // First-byte latency
    doReset();
    popLog.delete();
    rdyMode          = 1;
    RequestOutBuffer = 1'b1;
    CodeIn           = 9'h0A5;
    tick();
    RequestOutBuffer = 1'b0;
    modelAccept(9'h0A5);
    check("lat_n1_valid", ByteValid, 0);
    tick();
    check("lat_n2_valid", ByteValid, 1);
    check("lat_n2_byte", ByteOut, 8'hA5);
    closeStream();
    waitDone("b_done");
    check("b_count", popLog.size(), 2);
    if (popLog.size() == 2) begin
      check("b_byte0", popLog[0], 8'hA5);
      check("b_byte1", popLog[1], 8'h00);
    end

    // Backpressure: FIFO fills, controller holds, then drains in order
    doReset();
    popLog.delete();
    rdyMode = 0;
    sent    = 0;
    for (int k = 0; k < 16; k++) begin
      sendCode(9'h155, 1'b0, 30, ok);
      if (!ok) break;
      sent++;
    end
    check("c_stall_codes", sent, 8);
    check("c_stall_inready", InReady, 0);
    check("c_stall_valid", ByteValid, 1);
    check("c_stall_head", ByteOut, 8'h55);
    check("c_stall_error", Error, 0);
    rdyMode = 1;
    for (int k = sent; k < 16; k++) begin
      sendCode(9'h155, 1'b0, 200, ok);
      check("c_resume_send", ok, 1);
    end
    closeStream();
    waitDone("c_done");
    check("c_count", popLog.size(), 18);
    if (popLog.size() >= 2) begin
      check("c_byte0", popLog[0], 8'h55);
      check("c_byte1", popLog[1], 8'hAB);
    end

    // Dropped strobe sets sticky Error
    doReset();
    popLog.delete();
    sendCode(9'h0A5, 1'b0, 20, ok);
    check("d_send", ok, 1);
    RequestOutBuffer = 1'b1;
    CodeIn           = 9'h123;
    tick();
    RequestOutBuffer = 1'b0;
    expErr           = 1'b1;
    check("d_err_set", Error, 1);
    repeat (5) tick();
    check("d_err_sticky", Error, 1);
    closeStream();
    waitDone("d_done");
    check("d_err_after_done", Error, 1);
    check("d_count", popLog.size(), 2);
    doReset();
    check("d_err_cleared", Error, 0);

    // Reset while FIFO holds bytes
    popLog.delete();
    rdyMode = 0;
    for (int k = 0; k < 3; k++) begin
      sendCode(9'h0F0 + 9'(k), 1'b0, 30, ok);
      check("e_send", ok, 1);
    end
    repeat (4) tick();
    check("e_valid_before", ByteValid, 1);
    #2;
    reset = 1'b1;
    #1;
    check("e_async_valid", ByteValid, 0);
    check("e_async_byteout", ByteOut, 0);
    check("e_async_inready", InReady, 0);
    doReset();
    rdyMode = 1;
    pops    = popLog.size();
    repeat (20) tick();
    check("e_no_bytes", popLog.size(), pops);
    check("e_valid_after", ByteValid, 0);

    // Randomized streams
    rdyMode = 2;
    for (int s = 0; s < 12; s++) begin
      n  = $urandom_range(0, 12);
      wc = 1'b0;
      for (int k = 0; k < n; k++) begin
        repeat ($urandom_range(0, 2)) tick();
        c  = CODE_W'($urandom());
        wc = (k == n - 1) && ($urandom_range(0, 1) == 1);
        sendCode(c, wc, 500, ok);
        check("r_send", ok, 1);
      end
      if (!wc) closeStream();
      waitDone("r_done");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
